imem_uart_loader: RTL and testbench

IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

---
 rtl/imem_uart_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_uart_loader.sv
// -----------------------------------------------------------------------------
// imem_uart_loader
//
// Streams a program image from a UART byte receiver into instruction memory
// and holds the core in reset until the whole image has been written.
//
// Byte stream: 4-byte little-endian word count N, then N instruction words,
// each 4 bytes little-endian (first byte lands in bits 7:0).
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   synchronous active-high reset
//   rx_valid     in   byte present on rx_data
//   rx_data      in   [7:0] received byte
//   rx_ready     out  loader accepts a byte this cycle (transfer = valid&ready)
//   reload       in   one-cycle request to restart loading (DONE/ERR only)
//   imem_we      out  instruction-memory write strobe, one cycle per word
//   imem_addr    out  [ADDR_W-1:0] word address of the write
//   imem_wdata   out  [31:0] instruction word to write
//   core_rst_n   out  active-low core reset, released only in DONE
//   load_done    out  program loaded, core running
//   load_err     out  header word count exceeded memory depth
//   words_loaded out  [ADDR_W:0] words written since the last load start
//
// Every output is decoded from the state register or taken straight from a
// register, so rx_valid/rx_data never reach an output combinationally.
// -----------------------------------------------------------------------------
module imem_uart_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  // One wider than the header so N == 2**ADDR_W compares without overflow.
  localparam logic [32:0] DEPTH = 33'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_LEN   = 3'd0,
    S_DATA  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [1:0]        byte_cnt;
  logic [31:0]       count_reg;
  logic [31:0]       word_reg;
  logic [ADDR_W:0]   wl_cnt;

  logic              xfer;
  logic              last_byte;
  logic [31:0]       n_full;
  logic [ADDR_W:0]   wl_inc;
  logic              wr_last;
  logic              restart;

  // ---------------------------------------------------------------------------
  // Handshake and decision terms
  // ---------------------------------------------------------------------------
  assign xfer      = rx_valid && rx_ready;
  assign last_byte = xfer && (byte_cnt == 2'd3);

  // Full header as it will look once the 4th byte is latched; the decision
  // is taken in the same cycle the byte arrives.
  assign n_full    = {rx_data, count_reg[23:0]};

  assign wl_inc    = wl_cnt + 1'b1;
  assign wr_last   = (32'(wl_inc) == count_reg);

  assign restart   = reload && ((state == S_DONE) || (state == S_ERR));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LEN;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN: begin
        if (last_byte) begin
          if (n_full == 32'd0) begin
            state_nxt = S_DONE;
          end else if ({1'b0, n_full} > DEPTH) begin
            state_nxt = S_ERR;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last_byte) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        state_nxt = wr_last ? S_DONE : S_DATA;
      end
      S_DONE, S_ERR: begin
        if (reload) begin
          state_nxt = S_LEN;
        end
      end
      default: begin
        state_nxt = S_LEN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode (state register only)
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_ready   = 1'b0;
    imem_we    = 1'b0;
    core_rst_n = 1'b0;
    load_done  = 1'b0;
    load_err   = 1'b0;
    case (state)
      S_LEN, S_DATA: begin
        rx_ready = 1'b1;
      end
      S_WRITE: begin
        imem_we = 1'b1;
      end
      S_DONE: begin
        core_rst_n = 1'b1;
        load_done  = 1'b1;
      end
      S_ERR: begin
        load_err = 1'b1;
      end
      default: begin
        rx_ready = 1'b0;
      end
    endcase
  end

  // The write address is the running count, so the last legal image
  // (N == DEPTH) ends at DEPTH-1 and never wraps.
  assign imem_addr    = wl_cnt[ADDR_W-1:0];
  assign imem_wdata   = word_reg;
  assign words_loaded = wl_cnt;

  // ---------------------------------------------------------------------------
  // Byte assembly and word counting
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt  <= 2'd0;
      count_reg <= 32'd0;
      word_reg  <= 32'd0;
      wl_cnt    <= '0;
    end else if (restart) begin
      byte_cnt  <= 2'd0;
      count_reg <= 32'd0;
      word_reg  <= 32'd0;
      wl_cnt    <= '0;
    end else begin
      if (xfer) begin
        // The 2-bit counter wraps to 0 on the 4th byte, which is exactly
        // the clear needed when leaving LEN or finishing a word.
        byte_cnt <= byte_cnt + 2'd1;
        if (state == S_LEN) begin
          count_reg[{byte_cnt, 3'b000} +: 8] <= rx_data;
        end else begin
          word_reg[{byte_cnt, 3'b000} +: 8] <= rx_data;
        end
      end
      if (state == S_WRITE) begin
        wl_cnt <= wl_inc;
      end
    end
  end

endmodule

// File: tb/tb_imem_uart_loader.sv
module tb_imem_uart_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: default depth 1024
  logic        a_rx_valid, a_rx_ready, a_reload, a_imem_we;
  logic [7:0]  a_rx_data;
  logic [9:0]  a_imem_addr;
  logic [31:0] a_imem_wdata;
  logic        a_core_rst_n, a_load_done, a_load_err;
  logic [10:0] a_words_loaded;

  // Instance B: depth 4
  logic        b_rx_valid, b_rx_ready, b_reload, b_imem_we;
  logic [7:0]  b_rx_data;
  logic [1:0]  b_imem_addr;
  logic [31:0] b_imem_wdata;
  logic        b_core_rst_n, b_load_done, b_load_err;
  logic [2:0]  b_words_loaded;

  imem_uart_loader #(.ADDR_W(10)) dut_a (
    .clk(clk), .rst(rst), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
    .rx_ready(a_rx_ready), .reload(a_reload), .imem_we(a_imem_we),
    .imem_addr(a_imem_addr), .imem_wdata(a_imem_wdata),
    .core_rst_n(a_core_rst_n), .load_done(a_load_done),
    .load_err(a_load_err), .words_loaded(a_words_loaded)
  );

  imem_uart_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst(rst), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
    .rx_ready(b_rx_ready), .reload(b_reload), .imem_we(b_imem_we),
    .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
    .core_rst_n(b_core_rst_n), .load_done(b_load_done),
    .load_err(b_load_err), .words_loaded(b_words_loaded)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        rdy;
    logic        we;
    logic        crn;
    logic        done;
    logic        err;
    logic [31:0] wl;
  } obs_t;

  typedef struct {
    logic [31:0] n;
    int          gap;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  wr_t         a_wr[$];
  wr_t         b_wr[$];
  logic [31:0] cur_words[$];

  // Write monitor: every cycle with the strobe high is one recorded write.
  always @(negedge clk) begin
    wr_t w;
    if (a_imem_we === 1'b1) begin
      w.addr = 32'(a_imem_addr);
      w.data = a_imem_wdata;
      a_wr.push_back(w);
    end
    if (b_imem_we === 1'b1) begin
      w.addr = 32'(b_imem_addr);
      w.data = b_imem_wdata;
      b_wr.push_back(w);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got hang want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic obs_t obs(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.rdy = a_rx_ready; o.we = a_imem_we; o.crn = a_core_rst_n;
      o.done = a_load_done; o.err = a_load_err; o.wl = 32'(a_words_loaded);
    end else begin
      o.rdy = b_rx_ready; o.we = b_imem_we; o.crn = b_core_rst_n;
      o.done = b_load_done; o.err = b_load_err; o.wl = 32'(b_words_loaded);
    end
    return o;
  endfunction

  task automatic set_in(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin a_rx_valid = v; a_rx_data = d; end
    else          begin b_rx_valid = v; b_rx_data = d; end
  endtask

  task automatic set_reload(input int sel, input logic r);
    if (sel == 0) a_reload = r; else b_reload = r;
  endtask

  // Presents one byte after an idle gap and holds it until accepted.
  // Returns just after the accepting rising edge.
  task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
    obs_t o;
    bit   ok;
    @(negedge clk);
    if (gap > 0) begin
      set_in(sel, 1'b0, 8'h00);
      repeat (gap) @(negedge clk);
    end
    set_in(sel, 1'b1, b);
    ok = 1'b0;
    for (int k = 0; k < 30; k++) begin
      o = obs(sel);
      @(posedge clk);
      if (o.rdy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout: got no rx_ready in 30 cycles want accept of %h", b);
    end
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[8*i +: 8];
      send_byte(sel, b, $urandom_range(0, maxgap));
    end
  endtask

  task automatic do_reload(input int sel);
    obs_t o;
    @(negedge clk);
    set_in(sel, 1'b0, 8'h00);
    set_reload(sel, 1'b1);
    @(negedge clk);
    set_reload(sel, 1'b0);
    o = obs(sel);
    chk("reload_rdy",  32'(o.rdy),  32'd1);
    chk("reload_err",  32'(o.err),  32'd0);
    chk("reload_done", 32'(o.done), 32'd0);
    chk("reload_crn",  32'(o.crn),  32'd0);
    chk("reload_wl",   o.wl,        32'd0);
  endtask

  // Reference model: a header above the memory depth is rejected, anything
  // else loads word i of the stream to address i and then releases the core.
  function automatic logic model_err(input logic [31:0] n, input int addr_w);
    return 64'(n) > (64'd1 << addr_w);
  endfunction

  // Sends header n and the words queued in cur_words, then checks the
  // outcome, the recorded writes and finally restarts with reload.
  task automatic apply_vec(input int sel, input logic [31:0] n, input int gap,
                           input logic exp_done, input logic exp_err);
    obs_t o;
    wr_t  got[$];
    int   bad;
    if (sel == 0) a_wr.delete(); else b_wr.delete();
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = n[8*i +: 8];
      send_byte(sel, b, $urandom_range(0, gap));
    end
    foreach (cur_words[i]) send_word(sel, cur_words[i], gap);
    @(negedge clk);
    set_in(sel, 1'b0, 8'h00);
    o = obs(sel);
    if (exp_err) begin
      chk("err_flag", 32'(o.err),  32'd1);
      chk("err_crn",  32'(o.crn),  32'd0);
      chk("err_rdy",  32'(o.rdy),  32'd0);
      chk("err_done", 32'(o.done), 32'd0);
    end else if (cur_words.size() == 0) begin
      chk("zero_done", 32'(o.done), 32'(exp_done));
      chk("zero_crn",  32'(o.crn),  32'd1);
      chk("zero_we",   32'(o.we),   32'd0);
    end else begin
      chk("last_we",   32'(o.we),   32'd1);
      chk("last_rdy",  32'(o.rdy),  32'd0);
      chk("last_crn",  32'(o.crn),  32'd0);
      chk("last_done", 32'(o.done), 32'd0);
      @(negedge clk);
      o = obs(sel);
      chk("done_flag", 32'(o.done), 32'(exp_done));
      chk("done_crn",  32'(o.crn),  32'd1);
      chk("done_err",  32'(o.err),  32'd0);
      chk("done_rdy",  32'(o.rdy),  32'd0);
    end
    chk("words_loaded", o.wl, 32'(cur_words.size()));
    got = (sel == 0) ? a_wr : b_wr;
    chk("write_count", 32'(got.size()), 32'(cur_words.size()));
    bad = 0;
    foreach (got[i]) begin
      if (i < cur_words.size()) begin
        if (got[i].addr !== 32'(i) || got[i].data !== cur_words[i]) begin
          if (bad == 0)
            $display("FAIL write_%0d: got addr %h data %h want addr %h data %h",
                     i, got[i].addr, got[i].data, 32'(i), cur_words[i]);
          bad++;
        end
      end
    end
    chk("write_content_errors", 32'(bad), 32'd0);
    do_reload(sel);
  endtask

  vec_t tbl[8];

  initial begin
    obs_t o;
    tbl[0] = '{32'd2,          0, 1'b1, 1'b0};
    tbl[1] = '{32'd0,          0, 1'b1, 1'b0};
    tbl[2] = '{32'd1025,       0, 1'b0, 1'b1};
    tbl[3] = '{32'd1,          3, 1'b1, 1'b0};
    tbl[4] = '{32'hFFFF_FFFF,  1, 1'b0, 1'b1};
    tbl[5] = '{32'd1024,       0, 1'b1, 1'b0};
    tbl[6] = '{32'd5,          2, 1'b1, 1'b0};
    tbl[7] = '{32'h0001_0000,  0, 1'b0, 1'b1};

    rst = 1'b1;
    a_rx_valid = 1'b0; a_rx_data = 8'h00; a_reload = 1'b0;
    b_rx_valid = 1'b0; b_rx_data = 8'h00; b_reload = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = obs(s);
      chk("rst_rdy",  32'(o.rdy),  32'd1);
      chk("rst_we",   32'(o.we),   32'd0);
      chk("rst_crn",  32'(o.crn),  32'd0);
      chk("rst_done", 32'(o.done), 32'd0);
      chk("rst_err",  32'(o.err),  32'd0);
      chk("rst_wl",   o.wl,        32'd0);
    end
    rst = 1'b0;

    // Known program: two words back-to-back.
    cur_words = '{32'h0010_0513, 32'h0020_0593};
    apply_vec(0, 32'd2, 0, 1'b1, 1'b0);

    // Table vectors with random payloads.
    foreach (tbl[v]) begin
      cur_words.delete();
      if (!tbl[v].exp_err)
        for (int i = 0; i < int'(tbl[v].n); i++) cur_words.push_back($urandom);
      apply_vec(0, tbl[v].n, tbl[v].gap, tbl[v].exp_done, tbl[v].exp_err);
    end

    // Reload in LEN is ignored; rst mid-word drops partial bytes and has
    // priority over a simultaneous reload and byte.
    send_byte(0, 8'h01, 0);
    send_byte(0, 8'h00, 0);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00);
    a_reload = 1'b1;
    @(negedge clk);
    a_reload = 1'b0;
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'h00, 0);
    send_byte(0, 8'hEF, 0);
    send_byte(0, 8'hBE, 0);
    @(negedge clk);
    rst = 1'b1;
    a_reload = 1'b1;
    set_in(0, 1'b1, 8'hAD);
    @(negedge clk);
    rst = 1'b0;
    a_reload = 1'b0;
    set_in(0, 1'b0, 8'h00);
    o = obs(0);
    chk("midrst_rdy", 32'(o.rdy), 32'd1);
    chk("midrst_wl",  o.wl,       32'd0);
    chk("midrst_no_write", 32'(a_wr.size()), 32'd0);
    cur_words = '{32'hDEAD_BEEF};
    apply_vec(0, 32'd1, 0, 1'b1, 1'b0);

    // N=1 with 3-cycle gaps, a byte held pending through WRITE and DONE.
    a_wr.delete();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] hdr;
      logic [7:0]  b;
      hdr = 32'd1;
      b = hdr[8*i +: 8];
      send_byte(0, b, 3);
    end
    send_byte(0, 8'h78, 3);
    send_byte(0, 8'h56, 3);
    send_byte(0, 8'h34, 3);
    send_byte(0, 8'h12, 3);
    @(negedge clk);
    set_in(0, 1'b1, 8'hAA);
    o = obs(0);
    chk("hold_we",  32'(o.we),  32'd1);
    chk("hold_rdy", 32'(o.rdy), 32'd0);
    repeat (4) @(negedge clk);
    o = obs(0);
    chk("hold_done",   32'(o.done), 32'd1);
    chk("hold_rdy2",   32'(o.rdy),  32'd0);
    chk("hold_wcount", 32'(a_wr.size()), 32'd1);
    if (a_wr.size() > 0) chk("hold_wdata", a_wr[0].data, 32'h1234_5678);
    do_reload(0);

    // Randomized loads checked against the model.
    for (int r = 0; r < 10; r++) begin
      logic [31:0] n;
      logic        e;
      int          sel_k;
      sel_k = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       n = 32'd0;
        1:       n = (sel_k == 0) ? 32'd1024 + $urandom_range(1, 300) : 32'd4 + $urandom_range(1, 300);
        2:       n = $urandom;
        default: n = (sel_k == 0) ? $urandom_range(1, 7) : $urandom_range(1, 4);
      endcase
      e = model_err(n, (sel_k == 0) ? 10 : 2);
      cur_words.delete();
      if (!e) for (int i = 0; i < int'(n); i++) cur_words.push_back($urandom);
      apply_vec(sel_k, n, $urandom_range(0, 2), !e, e);
    end

    // Small memory: full-depth image and first illegal size.
    cur_words = '{32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003};
    apply_vec(1, 32'd4, 0, 1'b1, 1'b0);
    cur_words.delete();
    apply_vec(1, 32'd5, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
